sprite_motion_ctrl: RTL and testbench
=====================================

SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 640: visible width in pixels.
REQ-002 Parameter SCREEN_H, default 480: visible height in pixels.
REQ-003 Parameter RADIUS, default 100: sprite half-extent in pixels.
REQ-004 Parameters INIT_X, default 320, and INIT_Y, default 240: sprite centre after reset.
REQ-005 clk  input  1  single clock; all state is in this domain.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 frame_tick  input  1  one-cycle pulse at the start of vertical blanking.
REQ-008 pause  input  1  high = ignore frame_tick (motion frozen).
REQ-009 speed  input  4  pixels moved per frame on each axis; 0 = stationary.
REQ-010 ball_x  output  10  published sprite centre X.
REQ-011 ball_y  output  10  published sprite centre Y.
REQ-012 dir_x  output  1  1 = moving right, 0 = moving left.
REQ-013 dir_y  output  1  1 = moving down, 0 = moving up.
REQ-014 busy  output  1  high while an update is in progress (state != IDLE).
REQ-015 bounce  output  1  one-cycle pulse when any edge collision occurred in the update.
REQ-016 bounce_cnt  output  8  saturating collision count (see Configuration).

Function
REQ-017 FSM states IDLE, MOVE_X, MOVE_Y, PUBLISH; IDLE->MOVE_X on frame_tick=1 and pause=0; MOVE_X->MOVE_Y->PUBLISH->IDLE unconditionally, one cycle each.
REQ-018 speed SHALL be captured on the frame_tick cycle; later changes do not affect the update in progress.
REQ-019 frame_tick while busy=1, or while pause=1, SHALL be ignored (no queuing).
REQ-020 MOVE_X: arithmetic on 11-bit unsigned; right: if x+speed >= SCREEN_W-1-RADIUS then next x = SCREEN_W-1-RADIUS, dir_x := 0, collision flagged; else x+speed.
REQ-021 MOVE_X left: if x <= RADIUS+speed then next x = RADIUS, dir_x := 1, collision flagged; else x-speed.
REQ-022 MOVE_Y: identical rules using y, dir_y, SCREEN_H.
REQ-023 speed=0: position unchanged; collision flagged only if already at a limit while moving into it.
REQ-024 ball_x and ball_y SHALL change together only on the PUBLISH->IDLE edge (tear-free); latency frame_tick to new outputs = 3 cycles after the tick edge.
REQ-025 dir_x/dir_y SHALL update in the same cycle as ball_x/ball_y.
REQ-026 bounce SHALL pulse for exactly one cycle, coincident with the output update, once per update even if both axes collide (corner).
REQ-027 Published position SHALL always satisfy RADIUS <= x <= SCREEN_W-1-RADIUS and the Y equivalent.

Reset
REQ-028 On rst_n low: state IDLE, ball_x=INIT_X, ball_y=INIT_Y, dir_x=1, dir_y=1, busy=0, bounce=0, bounce_cnt=0, captured speed=0.
REQ-029 Reset asserted mid-update SHALL abort the update; no partial position published.
REQ-030 First frame_tick honoured is the first one sampled with rst_n high.

Configuration
REQ-031 Macro SPRITE_BOUNCE_CNT_EN defined: bounce_cnt increments by 1 on each bounce pulse, saturating at 255.
REQ-032 Macro undefined: bounce_cnt tied to 0, no counter register; all other behaviour identical.

Structure
REQ-033 Shared package sprite_pkg holds the FSM state enumeration and default screen/radius constants, shared with the pixel-generation logic.
REQ-034 One sub-module, axis_step, implements the REQ-020/021 step-and-clamp for one axis; instantiated or time-shared for X and Y.

Verification
REQ-035 Reset, then frame_tick, speed=1 -> after 3 cycles ball_x=321, ball_y=241, bounce=0, busy high for 3 cycles.
REQ-036 x=535 moving right, speed=8 -> ball_x=539, dir_x=0, bounce pulse 1 cycle; bounce_cnt=1 with macro, 0 without.
REQ-037 Position (539,379) moving right/down, speed=4 -> (539,379), both dirs flip, single bounce, bounce_cnt +1.
REQ-038 pause=1 with 10 frame_ticks -> outputs unchanged, busy never asserts; second frame_tick during busy ignored.
REQ-039 rst_n low in MOVE_Y -> outputs return to (320,240), dirs 1, no bounce pulse.
REQ-040 300 corner bounces with macro -> bounce_cnt holds 255.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite motion types and default screen geometry.
// Also used by the pixel-generation logic.
package sprite_pkg;

   localparam int unsigned SCREEN_W_DEF = 640;
   localparam int unsigned SCREEN_H_DEF = 480;
   localparam int unsigned RADIUS_DEF   = 100;
   localparam int unsigned INIT_X_DEF   = 320;
   localparam int unsigned INIT_Y_DEF   = 240;

   localparam int unsigned POS_W   = 10;
   localparam int unsigned SPEED_W = 4;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MOVE_X  = 2'd1,
      MOVE_Y  = 2'd2,
      PUBLISH = 2'd3
   } sprite_state_t;

   // Position and direction of one axis travelling together through the update
   typedef struct packed {
      logic [POS_W-1:0] pos;
      logic             dir;
   } axis_t;

   // Saturating increment for the collision counter
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sprite_motion_ctrl_axis_step.sv
// axis_step: one-axis step-and-clamp. Moves the position by speed in the
// current direction; on reaching or passing a limit it clamps to the limit,
// reverses direction and flags a collision. Purely combinational.
module axis_step
   import sprite_pkg::*;
(
   input  logic [POS_W-1:0]   i_pos,
   input  logic               i_dir,
   input  logic [SPEED_W-1:0] i_speed,
   input  logic [POS_W-1:0]   i_lo,
   input  logic [POS_W-1:0]   i_hi,
   output logic [POS_W-1:0]   o_pos_c,
   output logic               o_dir_c,
   output logic               o_hit_c
);

   localparam int unsigned AW = POS_W + 1;

   logic [AW-1:0] w_pos;
   logic [AW-1:0] w_spd;
   logic [AW-1:0] w_lo;
   logic [AW-1:0] w_hi;
   logic [AW-1:0] w_fwd;
   logic [AW-1:0] w_lo_reach;

   assign w_pos      = AW'(i_pos);
   assign w_spd      = AW'(i_speed);
   assign w_lo       = AW'(i_lo);
   assign w_hi       = AW'(i_hi);
   assign w_fwd      = w_pos + w_spd;
   assign w_lo_reach = w_lo + w_spd;

   // Step toward the travel direction, clamping and reversing at a limit
   always_comb begin
      o_pos_c = i_pos;
      o_dir_c = i_dir;
      o_hit_c = 1'b0;
      if (i_dir) begin
         if (w_fwd >= w_hi) begin
            o_pos_c = i_hi;
            o_dir_c = 1'b0;
            o_hit_c = 1'b1;
         end else begin
            o_pos_c = POS_W'(w_fwd);
         end
      end else begin
         if (w_pos <= w_lo_reach) begin
            o_pos_c = i_lo;
            o_dir_c = 1'b1;
            o_hit_c = 1'b1;
         end else begin
            o_pos_c = POS_W'(w_pos - w_spd);
         end
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: bouncing sprite position controller. Each accepted
// frame_tick runs a four-state update (IDLE->MOVE_X->MOVE_Y->PUBLISH) on
// working copies; the published position/direction change together on the
// PUBLISH->IDLE edge so the pixel logic never sees a torn coordinate pair.
// Optional macro SPRITE_BOUNCE_CNT_EN enables the saturating bounce counter.
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int unsigned SCREEN_W = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H = SCREEN_H_DEF,
   parameter int unsigned RADIUS   = RADIUS_DEF,
   parameter int unsigned INIT_X   = INIT_X_DEF,
   parameter int unsigned INIT_Y   = INIT_Y_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               pause,
   input  logic [SPEED_W-1:0] speed,
   output logic [POS_W-1:0]   ball_x,
   output logic [POS_W-1:0]   ball_y,
   output logic               dir_x,
   output logic               dir_y,
   output logic               busy,
   output logic               bounce,
   output logic [CNT_W-1:0]   bounce_cnt
);

   localparam logic [POS_W-1:0] LIM_LO = POS_W'(RADIUS);
   localparam logic [POS_W-1:0] X_HI   = POS_W'(SCREEN_W - 1 - RADIUS);
   localparam logic [POS_W-1:0] Y_HI   = POS_W'(SCREEN_H - 1 - RADIUS);
   localparam logic [POS_W-1:0] X_INIT = POS_W'(INIT_X);
   localparam logic [POS_W-1:0] Y_INIT = POS_W'(INIT_Y);

   sprite_state_t      r_state;
   sprite_state_t      w_next;
   logic               w_start;
   logic [SPEED_W-1:0] r_speed;
   axis_t              r_wx;
   axis_t              r_wy;
   logic               r_hit;
   axis_t              w_sel;
   logic [POS_W-1:0]   w_sel_hi;
   logic [POS_W-1:0]   w_step_pos;
   logic               w_step_dir;
   logic               w_step_hit;

   assign w_start = frame_tick & ~pause & (r_state == IDLE);

   // State register; busy is registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         busy    <= 1'b0;
      end else begin
         r_state <= w_next;
         busy    <= (w_next != IDLE);
      end
   end

   // Next-state logic: ticks outside IDLE or while paused are dropped
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = MOVE_X;
         MOVE_X:  w_next = MOVE_Y;
         MOVE_Y:  w_next = PUBLISH;
         PUBLISH: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Single step unit time-shared between the X and Y phases
   always_comb begin
      w_sel    = r_wx;
      w_sel_hi = X_HI;
      if (r_state == MOVE_Y) begin
         w_sel    = r_wy;
         w_sel_hi = Y_HI;
      end
   end

   axis_step u_axis_step (
      .i_pos   (w_sel.pos),
      .i_dir   (w_sel.dir),
      .i_speed (r_speed),
      .i_lo    (LIM_LO),
      .i_hi    (w_sel_hi),
      .o_pos_c (w_step_pos),
      .o_dir_c (w_step_dir),
      .o_hit_c (w_step_hit)
   );

   // Working copies, captured speed and the published outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_speed <= '0;
         r_wx    <= '{pos: X_INIT, dir: 1'b1};
         r_wy    <= '{pos: Y_INIT, dir: 1'b1};
         r_hit   <= 1'b0;
         ball_x  <= X_INIT;
         ball_y  <= Y_INIT;
         dir_x   <= 1'b1;
         dir_y   <= 1'b1;
         bounce  <= 1'b0;
      end else begin
         bounce <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_speed <= speed;
                  r_wx    <= '{pos: ball_x, dir: dir_x};
                  r_wy    <= '{pos: ball_y, dir: dir_y};
               end
            end
            MOVE_X: begin
               r_wx  <= '{pos: w_step_pos, dir: w_step_dir};
               r_hit <= w_step_hit;
            end
            MOVE_Y: begin
               r_wy  <= '{pos: w_step_pos, dir: w_step_dir};
               r_hit <= r_hit | w_step_hit;
            end
            PUBLISH: begin
               ball_x <= r_wx.pos;
               ball_y <= r_wy.pos;
               dir_x  <= r_wx.dir;
               dir_y  <= r_wy.dir;
               bounce <= r_hit;
            end
            default: ;
         endcase
      end
   end

`ifdef SPRITE_BOUNCE_CNT_EN
   logic [CNT_W-1:0] r_bounce_cnt;

   // Count updates that collided, advancing with the bounce pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bounce_cnt <= '0;
      end else if ((r_state == PUBLISH) && r_hit) begin
         r_bounce_cnt <= sat_inc(r_bounce_cnt);
      end
   end

   assign bounce_cnt = r_bounce_cnt;
`else
   assign bounce_cnt = '0;
`endif

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: randomized self-checking bench with a frame-level
// reference model. A second instance starts in the bottom-right corner.
module tb_sprite_motion_ctrl;

   localparam int LO  = 100;
   localparam int XHI = 539;
   localparam int YHI = 379;

   logic       clk;
   logic       rst_n;
   logic       frame_tick;
   logic       frame_tick_c;
   logic       pause;
   logic [3:0] speed;

   logic [9:0] ball_x, ball_y, c_ball_x, c_ball_y;
   logic       dir_x, dir_y, busy, bounce;
   logic       c_dir_x, c_dir_y, c_busy, c_bounce;
   logic [7:0] bounce_cnt, c_bounce_cnt;

   int n_checks;
   int n_fail;

   // Reference model state per instance: published view plus pending update
   int mx[2], my[2], mcnt[2], bl[2], nx[2], ny[2];
   bit mdx[2], mdy[2], ndx[2], ndy[2], nhit[2], mb[2];

   sprite_motion_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause), .speed(speed),
      .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
      .busy(busy), .bounce(bounce), .bounce_cnt(bounce_cnt)
   );

   sprite_motion_ctrl #(.INIT_X(539), .INIT_Y(379)) u_dut_corner (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick_c), .pause(pause), .speed(speed),
      .ball_x(c_ball_x), .ball_y(c_ball_y), .dir_x(c_dir_x), .dir_y(c_dir_y),
      .busy(c_busy), .bounce(c_bounce), .bounce_cnt(c_bounce_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void axis_model(input int p, input bit d, input int s, input int hi,
                                      output int np, output bit nd, output bit hit);
      np = p; nd = d; hit = 1'b0;
      if (d) begin
         if (p + s >= hi) begin np = hi; nd = 1'b0; hit = 1'b1; end
         else np = p + s;
      end else begin
         if (p <= LO + s) begin np = LO; nd = 1'b1; hit = 1'b1; end
         else np = p - s;
      end
   endfunction

   function automatic int exp_cnt(input int i);
`ifdef SPRITE_BOUNCE_CNT_EN
      return (mcnt[i] > 255) ? 255 : mcnt[i];
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      mx[0] = 320; my[0] = 240; mx[1] = 539; my[1] = 379;
      for (int i = 0; i < 2; i++) begin
         mdx[i] = 1'b1; mdy[i] = 1'b1; mcnt[i] = 0; bl[i] = 0; mb[i] = 1'b0; nhit[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; frame_tick = 1'b0; frame_tick_c = 1'b0; pause = 1'b0; speed = 4'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   // One clock: apply inputs, advance the model across the edge, settle
   task automatic drive_cycle(input bit t0, input bit t1, input bit ps, input logic [3:0] spd);
      bit acc[2];
      bit hx, hy;
      frame_tick = t0; frame_tick_c = t1; pause = ps; speed = spd;
      acc[0] = t0 && !ps && (bl[0] == 0);
      acc[1] = t1 && !ps && (bl[1] == 0);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         mb[i] = 1'b0;
         if (bl[i] > 0) begin
            bl[i]--;
            if (bl[i] == 0) begin
               mx[i] = nx[i]; my[i] = ny[i]; mdx[i] = ndx[i]; mdy[i] = ndy[i];
               if (nhit[i]) begin mb[i] = 1'b1; mcnt[i]++; end
            end
         end else if (acc[i]) begin
            axis_model(mx[i], mdx[i], int'(spd), XHI, nx[i], ndx[i], hx);
            axis_model(my[i], mdy[i], int'(spd), YHI, ny[i], ndy[i], hy);
            nhit[i] = hx | hy;
            bl[i] = 3;
         end
      end
      #1;
   endtask

   // A full update on the main instance; speed is scrambled while busy
   task automatic frame(input logic [3:0] s);
      drive_cycle(1'b1, 1'b0, 1'b0, s);
      repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 4'($urandom));
   endtask

   task automatic test_reset();
      do_reset();
      n_checks += 9;
      if (ball_x !== 10'd320) begin n_fail++; $display("FAIL rst_x: got %0d exp 320", ball_x); end
      if (ball_y !== 10'd240) begin n_fail++; $display("FAIL rst_y: got %0d exp 240", ball_y); end
      if (dir_x !== 1'b1 || dir_y !== 1'b1) begin n_fail++; $display("FAIL rst_dir: got %b%b exp 11", dir_x, dir_y); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
      if (bounce !== 1'b0) begin n_fail++; $display("FAIL rst_bounce: got %b exp 0", bounce); end
      if (bounce_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", bounce_cnt); end
      if (c_ball_x !== 10'd539) begin n_fail++; $display("FAIL rst_cx: got %0d exp 539", c_ball_x); end
      if (c_ball_y !== 10'd379) begin n_fail++; $display("FAIL rst_cy: got %0d exp 379", c_ball_y); end
      if (c_busy !== 1'b0) begin n_fail++; $display("FAIL rst_cbusy: got %b exp 0", c_busy); end
   endtask

   task automatic test_basic();
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 4'd1);
      for (int k = 0; k < 3; k++) begin
         n_checks += 2;
         if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy[%0d]: got %b exp 1", k, busy); end
         if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
            n_fail++; $display("FAIL basic_hold[%0d]: got (%0d,%0d) exp (320,240)", k, ball_x, ball_y);
         end
         drive_cycle(1'b0, 1'b0, 1'b0, 4'd15);
      end
      n_checks += 4;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b exp 0", busy); end
      if (ball_x !== 10'd321 || ball_y !== 10'd241) begin
         n_fail++; $display("FAIL basic_pos: got (%0d,%0d) exp (321,241)", ball_x, ball_y);
      end
      if (bounce !== 1'b0) begin n_fail++; $display("FAIL basic_bounce: got %b exp 0", bounce); end
      if (dir_x !== 1'b1 || dir_y !== 1'b1) begin n_fail++; $display("FAIL basic_dir: got %b%b exp 11", dir_x, dir_y); end
   endtask

   task automatic test_pause();
      int x0, y0;
      x0 = mx[0]; y0 = my[0];
      for (int k = 0; k < 10; k++) begin
         drive_cycle(1'b1, 1'b0, 1'b1, 4'd7);
         drive_cycle(1'b0, 1'b0, 1'b1, 4'd7);
         n_checks += 2;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL pause_busy[%0d]: got %b exp 0", k, busy); end
         if (ball_x !== 10'(x0) || ball_y !== 10'(y0)) begin
            n_fail++; $display("FAIL pause_pos[%0d]: got (%0d,%0d) exp (%0d,%0d)", k, ball_x, ball_y, x0, y0);
         end
      end
      drive_cycle(1'b1, 1'b0, 1'b0, 4'd3);
      drive_cycle(1'b1, 1'b0, 1'b0, 4'd9);
      drive_cycle(1'b0, 1'b0, 1'b0, 4'd9);
      drive_cycle(1'b0, 1'b0, 1'b0, 4'd9);
      for (int k = 0; k < 4; k++) begin
         n_checks += 2;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_tick_idle[%0d]: got %b exp 0", k, busy); end
         if (ball_x !== 10'(mx[0]) || ball_y !== 10'(my[0])) begin
            n_fail++; $display("FAIL busy_tick_pos[%0d]: got (%0d,%0d) exp (%0d,%0d)", k, ball_x, ball_y, mx[0], my[0]);
         end
         drive_cycle(1'b0, 1'b0, 1'b0, 4'd9);
      end
   endtask

   task automatic test_edge_x();
      int c0;
      do_reset();
      repeat (14) frame(4'd15);
      frame(4'd5);
      n_checks += 2;
      if (ball_x !== 10'd535 || dir_x !== 1'b1) begin
         n_fail++; $display("FAIL edge_pre: got x=%0d dx=%b exp x=535 dx=1", ball_x, dir_x);
      end
      if (ball_y !== 10'(my[0])) begin n_fail++; $display("FAIL edge_pre_y: got %0d exp %0d", ball_y, my[0]); end
      c0 = mcnt[0];
      frame(4'd8);
      n_checks += 4;
      if (ball_x !== 10'd539 || dir_x !== 1'b0) begin
         n_fail++; $display("FAIL edge_x: got x=%0d dx=%b exp x=539 dx=0", ball_x, dir_x);
      end
      if (bounce !== 1'b1) begin n_fail++; $display("FAIL edge_bounce: got %b exp 1", bounce); end
      if (mcnt[0] !== c0 + 1) begin n_fail++; $display("FAIL edge_model_cnt: got %0d exp %0d", mcnt[0], c0 + 1); end
      if (bounce_cnt !== 8'(exp_cnt(0))) begin n_fail++; $display("FAIL edge_cnt: got %0d exp %0d", bounce_cnt, exp_cnt(0)); end
      drive_cycle(1'b0, 1'b0, 1'b0, 4'd0);
      n_checks++;
      if (bounce !== 1'b0) begin n_fail++; $display("FAIL edge_pulse_len: got %b exp 0", bounce); end
   endtask

   task automatic test_corner();
      do_reset();
      drive_cycle(1'b0, 1'b1, 1'b0, 4'd4);
      repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 4'($urandom));
      n_checks += 4;
      if (c_ball_x !== 10'd539 || c_ball_y !== 10'd379) begin
         n_fail++; $display("FAIL corner_pos: got (%0d,%0d) exp (539,379)", c_ball_x, c_ball_y);
      end
      if (c_dir_x !== 1'b0 || c_dir_y !== 1'b0) begin n_fail++; $display("FAIL corner_dir: got %b%b exp 00", c_dir_x, c_dir_y); end
      if (c_bounce !== 1'b1) begin n_fail++; $display("FAIL corner_bounce: got %b exp 1", c_bounce); end
`ifdef SPRITE_BOUNCE_CNT_EN
      if (c_bounce_cnt !== 8'd1) begin n_fail++; $display("FAIL corner_cnt: got %0d exp 1", c_bounce_cnt); end
`else
      if (c_bounce_cnt !== 8'd0) begin n_fail++; $display("FAIL corner_cnt: got %0d exp 0", c_bounce_cnt); end
`endif
      drive_cycle(1'b0, 1'b0, 1'b0, 4'd0);
      n_checks++;
      if (c_bounce !== 1'b0) begin n_fail++; $display("FAIL corner_pulse_len: got %b exp 0", c_bounce); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      repeat (3) frame(4'($urandom_range(5, 15)));
      drive_cycle(1'b1, 1'b0, 1'b0, 4'd15);
      drive_cycle(1'b0, 1'b0, 1'b0, 4'd15);
      #2 rst_n = 1'b0;
      #1;
      n_checks += 4;
      if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
         n_fail++; $display("FAIL midrst_pos: got (%0d,%0d) exp (320,240)", ball_x, ball_y);
      end
      if (dir_x !== 1'b1 || dir_y !== 1'b1) begin n_fail++; $display("FAIL midrst_dir: got %b%b exp 11", dir_x, dir_y); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", busy); end
      if (bounce !== 1'b0) begin n_fail++; $display("FAIL midrst_bounce: got %b exp 0", bounce); end
      frame_tick = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 4'd15);
         n_checks += 2;
         if (bounce !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_after[%0d]: got bounce=%b busy=%b exp 0 0", k, bounce, busy);
         end
         if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
            n_fail++; $display("FAIL midrst_hold[%0d]: got (%0d,%0d) exp (320,240)", k, ball_x, ball_y);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 600; k++) begin
         drive_cycle(($urandom_range(0, 2) == 0), 1'b0, ($urandom_range(0, 4) == 0), 4'($urandom));
         n_checks += 6;
         if (ball_x !== 10'(mx[0]) || ball_y !== 10'(my[0])) begin
            n_fail++; $display("FAIL rnd_pos[%0d]: got (%0d,%0d) exp (%0d,%0d)", k, ball_x, ball_y, mx[0], my[0]);
         end
         if (dir_x !== mdx[0] || dir_y !== mdy[0]) begin
            n_fail++; $display("FAIL rnd_dir[%0d]: got %b%b exp %b%b", k, dir_x, dir_y, mdx[0], mdy[0]);
         end
         if (busy !== (bl[0] > 0)) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b exp %b", k, busy, (bl[0] > 0)); end
         if (bounce !== mb[0]) begin n_fail++; $display("FAIL rnd_bounce[%0d]: got %b exp %b", k, bounce, mb[0]); end
         if (bounce_cnt !== 8'(exp_cnt(0))) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d exp %0d", k, bounce_cnt, exp_cnt(0)); end
         if (ball_x < 10'(LO) || ball_x > 10'(XHI) || ball_y < 10'(LO) || ball_y > 10'(YHI)) begin
            n_fail++; $display("FAIL rnd_bounds[%0d]: got (%0d,%0d) exp within [%0d..%0d]x[%0d..%0d]", k, ball_x, ball_y, LO, XHI, LO, YHI);
         end
      end
   endtask

   task automatic test_saturate();
      int frames;
      do_reset();
      frames = 0;
      while (mcnt[0] < 300 && frames < 8000) begin
         frame(4'($urandom_range(8, 15)));
         frames++;
         n_checks += 2;
         if (ball_x !== 10'(mx[0]) || ball_y !== 10'(my[0])) begin
            n_fail++; $display("FAIL sat_pos[%0d]: got (%0d,%0d) exp (%0d,%0d)", frames, ball_x, ball_y, mx[0], my[0]);
         end
         if (bounce_cnt !== 8'(exp_cnt(0))) begin
            n_fail++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", frames, bounce_cnt, exp_cnt(0));
         end
      end
      n_checks += 2;
      if (mcnt[0] < 300) begin n_fail++; $display("FAIL sat_budget: got %0d bounces exp >= 300", mcnt[0]); end
`ifdef SPRITE_BOUNCE_CNT_EN
      if (bounce_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d exp 255", bounce_cnt); end
`else
      if (bounce_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_final: got %0d exp 0", bounce_cnt); end
`endif
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_reset();
      test_reset();
      test_basic();
      test_pause();
      test_edge_x();
      test_corner();
      test_reset_mid();
      test_random();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
